uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter and successor to the fixed 8-bit simplex TX.
- Adds a baud-rate divider, configurable data width, optional even/odd parity, and 1 or 2 stop bits.
- Adds a valid/ready input handshake and a frame-done pulse.
- Sits between a byte-producing client (FIFO, CPU register) and the serial pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_CLK  input  1  system clock, all logic on the rising edge.
i_RST  input  1  synchronous, active-high reset.
i_DATA  input  DATA_BITS  word to transmit; sampled only on accept.
i_VALID  input  1  client has a word.
o_READY  output  1  block can accept; high only in IDLE.
o_TX  output  1  serial line, registered, idles high.
o_BUSY  output  1  frame in progress (any state other than IDLE).
o_DONE  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock, i_CLK. Reset i_RST is synchronous and active-high.
- Reset values: state = IDLE, o_TX = 1, o_READY = 1, o_BUSY = 0, o_DONE = 0, and the bit and baud counters are 0.
- Reset mid-frame: the frame is aborted. On the next cycle o_TX = 1 and o_READY = 1. o_DONE is not pulsed.
- Accept: an accept occurs on a clock edge where i_VALID && o_READY.
  - i_DATA is latched into the shift register.
  - Parity is computed from the latched data: even = XOR of the data bits, odd = inverted XOR.
  - From the cycle after accept, o_READY = 0 and i_DATA is ignored.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Every state other than IDLE holds for exactly CLKS_PER_BIT cycles, timed by the baud counter.
  - START: o_TX = 0.
  - DATA: o_TX = shift_reg[0], LSB first. Shift right at each bit boundary. Leave DATA after DATA_BITS bits.
  - PARITY: entered only if PARITY_MODE != 0. o_TX = parity bit.
  - STOP: o_TX = 1 for STOP_BITS * CLKS_PER_BIT cycles.
- Latency: o_TX falls on the first cycle after the accept edge.
  - Frame length F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - On cycle F+1 after accept: state = IDLE, o_DONE = 1 for one cycle, o_READY = 1, o_BUSY = 0.
- Back-to-back frames: the client may hold i_VALID high continuously.
  - The next accept happens on the o_DONE cycle.
  - Guaranteed line gap between frames is exactly one idle-high cycle beyond the stop bits.
- Simultaneous i_RST and i_VALID: reset wins; no accept.
- Width rules:
  - Baud counter width = $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width = $clog2(DATA_BITS+1).
  - No arithmetic overflow is permitted within the legal parameter ranges.
- Illegal parameters (CLKS_PER_BIT < 2, STOP_BITS not in {1,2}, PARITY_MODE > 2): flagged by an elaboration-time check. Behaviour is not defined.
- o_TX is registered and glitch-free; it changes only on i_CLK edges.

Decomposition:
- Package uart_pkg:
  - State encoding localparams: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
  - Parity mode constants: PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
  - Shared with the future RX block.
- Sub-module uart_baud_tick (parameter CLKS_PER_BIT).
  - Inputs: i_CLK, i_RST, i_EN.
  - Output: o_TICK, a one-cycle pulse on the last cycle of each bit period.
  - Counter restarts when i_EN rises.
  - Reused by RX with a half-bit offset.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop; accept 0x2A at cycle 0.
   -> o_TX per 4-cycle bit: 0 | 0,1,0,1,0,1,0,0 | 1.
   -> o_DONE high at cycle 41 only; o_READY low for cycles 1..40.
2. Same configuration with PARITY_MODE=1, data 0x2A (three 1s).
   -> Parity bit = 1 during cycles 37..40; stop bit on cycles 41..44; o_DONE at 45.
   -> Repeat with PARITY_MODE=2 -> parity bit = 0.
3. STOP_BITS=2, DATA_BITS=5, data 0x1F.
   -> Data bits all 1, stop high for 8 cycles; F = 32; o_DONE at cycle 33.
4. i_VALID held high with data 0x55 then 0xA3.
   -> Second start bit falls at cycle 42, i.e. exactly one idle cycle after the stop bit.
   -> Both frames decode correctly LSB-first.
5. Assert i_RST at cycle 15 mid-DATA.
   -> Cycle 16: o_TX = 1, o_READY = 1, o_BUSY = 0, no o_DONE.
   -> A new accept at cycle 17 produces a clean full frame.
6. Change i_DATA every cycle during a frame.
   -> Transmitted bits match only the value sampled on the accept edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver:
// FSM state encoding, parity mode codes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned PAR_NONE      = 32'd0;
    localparam int unsigned PAR_EVEN      = 32'd1;
    localparam int unsigned PAR_ODD       = 32'd2;
    localparam int unsigned MAX_DATA_BITS = 32'd9;

    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses o_TICK on the last cycle of every CLKS_PER_BIT
// period and restarts from zero whenever i_EN rises.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 32'd16
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_EN,
    output logic o_TICK
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 32'd2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Counter held at zero while disabled; the tick is registered one count early
    always_ff @(posedge i_CLK) begin
        if (i_RST || !i_EN) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == CNT_PRE);
        end
    end

    assign o_TICK = r_tick;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, configurable data width,
// optional parity, one or two stop bits, registered serial output.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'd16,
    parameter int unsigned DATA_BITS    = 32'd8,
    parameter int unsigned PARITY_MODE  = 32'd0,
    parameter int unsigned STOP_BITS    = 32'd1
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [DATA_BITS-1:0] i_DATA,
    input  logic                 i_VALID,
    output logic                 o_READY,
    output logic                 o_TX,
    output logic                 o_BUSY,
    output logic                 o_DONE
);

    if (CLKS_PER_BIT < 32'd2 || DATA_BITS < 32'd5 || DATA_BITS > MAX_DATA_BITS ||
        PARITY_MODE > PAR_ODD || (STOP_BITS != 32'd1 && STOP_BITS != 32'd2)) begin : g_bad_params
        $error("uart_tx_param: illegal parameter set");
    end

    localparam int unsigned          BIT_CNT_W  = $clog2(DATA_BITS + 32'd1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(DATA_BITS - 32'd1);
    localparam logic                 LAST_STOP  = 1'(STOP_BITS - 32'd1);
    localparam logic                 HAS_PARITY = (PARITY_MODE != PAR_NONE);

    uart_state_e            r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   r_stop_cnt;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_tick;
    logic                   w_parity;

    assign w_parity = calc_parity(MAX_DATA_BITS'(i_DATA), PARITY_MODE == PAR_ODD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_EN  (r_busy),
        .o_TICK(w_tick)
    );

    // Frame sequencer; o_TX is always loaded with the level of the state being entered
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_VALID && r_ready) begin
                        r_shift   <= i_DATA;
                        r_parity  <= w_parity;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_tx    <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= S_STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_state    <= S_STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == LAST_STOP) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_READY = r_ready;
    assign o_TX    = r_tx;
    assign o_BUSY  = r_busy;
    assign o_DONE  = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param over four parameter sets (CLKS_PER_BIT = 4):
// 8N1, 8E1, 8O1 and 5N2, one instance each.
module tb_uart_tx_param;

    localparam int N_DUT = 4;
    localparam int CPB   = 4;

    function automatic int cfg_db(input int g);
        return (g == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_pm(input int g);
        return (g == 1) ? 1 : ((g == 2) ? 2 : 0);
    endfunction
    function automatic int cfg_sb(input int g);
        return (g == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_len(input int g);
        return (1 + cfg_db(g) + ((cfg_pm(g) != 0) ? 1 : 0) + cfg_sb(g)) * CPB;
    endfunction

    logic clk = 1'b0;
    logic [N_DUT-1:0]       rst, valid, tx, ready, busy, done;
    logic [N_DUT-1:0][8:0]  data;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int DB = cfg_db(g);
        uart_tx_param #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB),
            .PARITY_MODE (cfg_pm(g)),
            .STOP_BITS   (cfg_sb(g))
        ) u_dut (
            .i_CLK  (clk),
            .i_RST  (rst[g]),
            .i_DATA (data[g][DB-1:0]),
            .i_VALID(valid[g]),
            .o_READY(ready[g]),
            .o_TX   (tx[g]),
            .o_BUSY (busy[g]),
            .o_DONE (done[g])
        );
    end

    int checks;
    int errors;
    int rel;
    bit cmp_en;

    // Reference model: position within the current frame (0 = idle) and the line bits of that frame
    int               pos [N_DUT];
    logic [15:0]      frame [N_DUT];
    logic [N_DUT-1:0] done_exp;

    task automatic build_frame(input int g, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < cfg_db(g); i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (cfg_pm(g) != 0) f[1 + cfg_db(g)] = (cfg_pm(g) == 2) ? ~p : p;
        frame[g] = f;
    endtask

    initial begin
        for (int g = 0; g < N_DUT; g++) begin
            pos[g]   = 0;
            frame[g] = '1;
        end
        done_exp = '0;
        forever begin
            @(posedge clk);
            for (int g = 0; g < N_DUT; g++) begin
                if (rst[g]) begin
                    pos[g]      = 0;
                    done_exp[g] = 1'b0;
                end else if (pos[g] == 0) begin
                    done_exp[g] = 1'b0;
                    if (valid[g]) begin
                        build_frame(g, data[g]);
                        pos[g] = 1;
                    end
                end else if (pos[g] == cfg_len(g)) begin
                    pos[g]      = 0;
                    done_exp[g] = 1'b1;
                end else begin
                    pos[g] = pos[g] + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model
    logic [3:0] got4, want4;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int g = 0; g < N_DUT; g++) begin
                    got4  = {tx[g], ready[g], busy[g], done[g]};
                    want4 = {(pos[g] == 0) ? 1'b1 : frame[g][(pos[g] - 1) / CPB],
                             pos[g] == 0, pos[g] != 0, done_exp[g]};
                    checks++;
                    if (got4 !== want4) begin
                        errors++;
                        $display("FAIL model_dut%0d t=%0t tx/ready/busy/done got %b required %b",
                                 g, $time, got4, want4);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, want);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        rel++;
    endtask

    // Moves to the sampling point of cycle n, where cycle 1 follows the accept edge
    task automatic adv_to(input int n);
        while (rel < n) step_edge();
        @(negedge clk);
    endtask

    task automatic launch(input int g, input logic [8:0] d, input bit hold);
        valid[g] = 1'b1;
        data[g]  = d;
        @(posedge clk);
        #1;
        rel = 1;
        if (!hold) valid[g] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    logic [9:0] t1_bits;

    initial begin
        rst    = '1;
        valid  = '0;
        data   = '0;
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rel    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst    = '0;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_dut0", {5'd0, tx[0], ready[0], busy[0], done[0]}, 9'b0_0000_1100);
        check("reset_dut3", {5'd0, tx[3], ready[3], busy[3], done[3]}, 9'b0_0000_1100);

        // 8N1, 0x2A: start, 0,1,0,1,0,1,0,0, stop
        t1_bits = 10'b10_0101_0100;
        launch(0, 9'h02A, 1'b0);
        for (int b = 0; b < 10; b++) begin
            adv_to(4 * b + 2);
            check($sformatf("t1_bit%0d", b), {8'd0, tx[0]}, {8'd0, t1_bits[b]});
        end
        adv_to(40);
        check("t1_c40_ready_done", {7'd0, ready[0], done[0]}, 9'd0);
        adv_to(41);
        check("t1_c41_done_ready_busy", {6'd0, done[0], ready[0], busy[0]}, 9'b0_0000_0110);
        adv_to(42);
        check("t1_c42_done", {8'd0, done[0]}, 9'd0);

        // 8E1 and 8O1 with 0x2A (three ones)
        launch(1, 9'h02A, 1'b0);
        adv_to(38);
        check("t2_even_parity", {8'd0, tx[1]}, 9'd1);
        adv_to(42);
        check("t2_even_stop", {8'd0, tx[1]}, 9'd1);
        adv_to(44);
        check("t2_even_c44_done", {8'd0, done[1]}, 9'd0);
        adv_to(45);
        check("t2_even_c45_done", {8'd0, done[1]}, 9'd1);
        launch(2, 9'h02A, 1'b0);
        adv_to(38);
        check("t2_odd_parity", {8'd0, tx[2]}, 9'd0);
        adv_to(45);
        check("t2_odd_c45_done", {8'd0, done[2]}, 9'd1);

        // 5N2 with 0x1F: F = 32
        launch(3, 9'h01F, 1'b0);
        adv_to(3);
        check("t3_start", {8'd0, tx[3]}, 9'd0);
        adv_to(20);
        check("t3_data", {8'd0, tx[3]}, 9'd1);
        adv_to(32);
        check("t3_c32_tx_done", {7'd0, tx[3], done[3]}, 9'b0_0000_0010);
        adv_to(33);
        check("t3_c33_done_busy", {7'd0, done[3], busy[3]}, 9'b0_0000_0010);

        // Back-to-back 0x55 then 0xA3 with valid held high
        launch(0, 9'h055, 1'b1);
        data[0] = 9'h0A3;
        adv_to(6);
        check("t4_f1_bit0", {8'd0, tx[0]}, 9'd1);
        adv_to(10);
        check("t4_f1_bit1", {8'd0, tx[0]}, 9'd0);
        adv_to(41);
        check("t4_c41_tx_done_ready", {6'd0, tx[0], done[0], ready[0]}, 9'b0_0000_0111);
        step_edge();
        valid[0] = 1'b0;
        adv_to(42);
        check("t4_c42_start", {8'd0, tx[0]}, 9'd0);
        adv_to(47);
        check("t4_f2_bit0", {8'd0, tx[0]}, 9'd1);
        adv_to(51);
        check("t4_f2_bit1", {8'd0, tx[0]}, 9'd1);
        adv_to(55);
        check("t4_f2_bit2", {8'd0, tx[0]}, 9'd0);
        adv_to(82);
        check("t4_f2_done", {8'd0, done[0]}, 9'd1);

        // Reset mid-DATA, then a fresh frame
        launch(0, 9'h096, 1'b0);
        adv_to(15);
        rst[0] = 1'b1;
        step_edge();
        rst[0] = 1'b0;
        adv_to(16);
        check("t5_c16_after_reset", {5'd0, tx[0], ready[0], busy[0], done[0]}, 9'b0_0000_1100);
        step_edge();
        valid[0] = 1'b1;
        data[0]  = 9'h03C;
        step_edge();
        valid[0] = 1'b0;
        adv_to(18);
        check("t5_new_start", {8'd0, tx[0]}, 9'd0);
        adv_to(58);
        check("t5_new_done", {8'd0, done[0]}, 9'd1);

        // i_DATA scrambled every cycle after accepting 0xC3 on the even-parity instance
        launch(1, 9'h0C3, 1'b0);
        for (int n = 2; n <= 46; n++) begin
            step_edge();
            data[1] = 9'($urandom);
            if (n == 6) begin
                @(negedge clk);
                check("t6_bit0", {8'd0, tx[1]}, 9'd1);
            end
            if (n == 14) begin
                @(negedge clk);
                check("t6_bit2", {8'd0, tx[1]}, 9'd0);
            end
            if (n == 38) begin
                @(negedge clk);
                check("t6_parity", {8'd0, tx[1]}, 9'd0);
            end
            if (n == 45) begin
                @(negedge clk);
                check("t6_done", {8'd0, done[1]}, 9'd1);
            end
        end

        repeat (4) step_edge();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
